// File: rtl/cmp_run_monitor_if.sv
// Bus bundle between the CMP run monitor and its environment: node instruction taps,
// participation mask, status flags and the (node, address) dump request stream.
interface cmp_run_monitor_if #(
  parameter int unsigned NODES  = 4,
  parameter int unsigned NODE_W = 2,
  parameter int unsigned INST_W = 32,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned ADDR_W = 8
);
  // Node i occupies bits [i*INST_W : i*INST_W+INST_W-1]; halted[i] is node i.
  logic [0:NODES*INST_W-1] inst_in;
  logic [NODES-1:0]        node_mask;
  logic                    dump_ready;
  logic [0:NODES-1]        halted;
  logic [CNT_W-1:0]        cycle_count;
  logic [CNT_W-1:0]        run_cycles;
  logic                    timeout;
  logic                    dump_valid;
  logic [NODE_W-1:0]       dump_node;
  logic [ADDR_W-1:0]       dump_addr;
  logic                    done;

  modport master (
    input  inst_in, node_mask, dump_ready,
    output halted, cycle_count, run_cycles, timeout,
           dump_valid, dump_node, dump_addr, done
  );

  modport slave (
    output inst_in, node_mask, dump_ready,
    input  halted, cycle_count, run_cycles, timeout,
           dump_valid, dump_node, dump_addr, done
  );
endinterface

// File: rtl/cmp_run_monitor.sv
// Run-control / completion monitor for the N-node Cardinal CMP: detects halt words,
// counts run cycles, waits out pipeline drain (or a timeout) and streams DMEM dump requests.
module cmp_run_monitor #(
  parameter int unsigned        NODES          = 4,
  parameter int unsigned        NODE_W         = 2,
  parameter int unsigned        INST_W         = 32,
  parameter logic [INST_W-1:0]  HALT_INST      = '0,
  parameter int unsigned        CNT_W          = 32,
  parameter int unsigned        DRAIN_CYCLES   = 5,
  parameter int unsigned        TIMEOUT_CYCLES = 500,
  parameter int unsigned        DUMP_DEPTH     = 128,
  parameter int unsigned        ADDR_W         = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  cmp_run_monitor_if.master   mon_bus
);

  localparam int unsigned       DRN_W     = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DUMP_DEPTH - 1);
  localparam logic [NODE_W-1:0] NODE_LAST = NODE_W'(NODES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_DUMP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  logic [0:NODES-1]    r_halted;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_run;
  logic                r_tmo;
  logic [DRN_W-1:0]    r_drn;
  logic                r_valid;
  logic [NODE_W-1:0]   r_node;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_done;

  state_t              w_nxt_state;
  logic [0:NODES-1]    w_nxt_halted;
  logic [CNT_W-1:0]    w_nxt_cnt;
  logic [CNT_W-1:0]    w_nxt_run;
  logic                w_nxt_tmo;
  logic [DRN_W-1:0]    w_nxt_drn;
  logic                w_nxt_valid;
  logic [NODE_W-1:0]   w_nxt_node;
  logic [ADDR_W-1:0]   w_nxt_addr;
  logic                w_nxt_done;

  logic [0:NODES-1]    w_match;
  logic [0:NODES-1]    w_halted_upd;
  logic                w_all_halt;
  logic                w_xfer;

  // Case-equality so an X/Z instruction never counts as the halt word.
  always_comb begin
    w_all_halt = 1'b1;
    for (int i = 0; i < NODES; i++) begin
      w_match[i]      = mon_bus.node_mask[i] &&
                        (mon_bus.inst_in[i*INST_W +: INST_W] === HALT_INST);
      w_halted_upd[i] = r_halted[i] | w_match[i];
      if (mon_bus.node_mask[i] && !w_halted_upd[i]) begin
        w_all_halt = 1'b0;
      end
    end
  end

  assign w_xfer = r_valid && mon_bus.dump_ready;

  // Next-state and next-output logic.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_halted = r_halted;
    w_nxt_cnt    = r_cnt;
    w_nxt_run    = r_run;
    w_nxt_tmo    = r_tmo;
    w_nxt_drn    = r_drn;
    w_nxt_valid  = r_valid;
    w_nxt_node   = r_node;
    w_nxt_addr   = r_addr;
    w_nxt_done   = r_done;

    case (r_state)
      S_IDLE: begin
        w_nxt_state = S_RUN;
        w_nxt_cnt   = '0;
      end

      S_RUN: begin
        w_nxt_halted = w_halted_upd;
        w_nxt_cnt    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        // A halt seen on the timeout cycle still counts as a clean completion.
        if (w_all_halt) begin
          w_nxt_run   = r_cnt;
          w_nxt_drn   = '0;
          w_nxt_state = S_DRAIN;
        end else if (r_cnt == TMO_LAST) begin
          w_nxt_run   = r_cnt;
          w_nxt_tmo   = 1'b1;
          w_nxt_valid = 1'b1;
          w_nxt_node  = '0;
          w_nxt_addr  = '0;
          w_nxt_state = S_DUMP;
        end
      end

      S_DRAIN: begin
        if (r_drn == DRN_LAST) begin
          w_nxt_valid = 1'b1;
          w_nxt_node  = '0;
          w_nxt_addr  = '0;
          w_nxt_state = S_DUMP;
        end else begin
          w_nxt_drn = r_drn + DRN_W'(1);
        end
      end

      S_DUMP: begin
        if (w_xfer) begin
          if (r_addr == ADDR_LAST) begin
            w_nxt_addr = '0;
            if (r_node == NODE_LAST) begin
              w_nxt_valid = 1'b0;
              w_nxt_done  = 1'b1;
              w_nxt_state = S_DONE;
            end else begin
              w_nxt_node = r_node + NODE_W'(1);
            end
          end else begin
            w_nxt_addr = r_addr + ADDR_W'(1);
          end
        end
      end

      S_DONE: begin
        w_nxt_done = 1'b1;
      end

      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_halted <= '0;
      r_cnt    <= '0;
      r_run    <= '0;
      r_tmo    <= 1'b0;
      r_drn    <= '0;
      r_valid  <= 1'b0;
      r_node   <= '0;
      r_addr   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_halted <= w_nxt_halted;
      r_cnt    <= w_nxt_cnt;
      r_run    <= w_nxt_run;
      r_tmo    <= w_nxt_tmo;
      r_drn    <= w_nxt_drn;
      r_valid  <= w_nxt_valid;
      r_node   <= w_nxt_node;
      r_addr   <= w_nxt_addr;
      r_done   <= w_nxt_done;
    end
  end

  assign mon_bus.halted      = r_halted;
  assign mon_bus.cycle_count = r_cnt;
  assign mon_bus.run_cycles  = r_run;
  assign mon_bus.timeout     = r_tmo;
  assign mon_bus.dump_valid  = r_valid;
  assign mon_bus.dump_node   = r_node;
  assign mon_bus.dump_addr   = r_addr;
  assign mon_bus.done        = r_done;

endmodule

// File: tb/tb_cmp_run_monitor.sv
// Directed bench for cmp_run_monitor: halt sequencing, drain latency, dump ordering,
// backpressure, timeout, empty mask and reset mid-dump.
module tb_cmp_run_monitor;
  localparam int unsigned NODES  = 4;
  localparam int unsigned NODE_W = 2;
  localparam int unsigned INST_W = 32;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmp_run_monitor_if #(.NODES(NODES), .NODE_W(NODE_W), .INST_W(INST_W),
                       .CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus ();

  cmp_run_monitor #(
    .NODES(NODES), .NODE_W(NODE_W), .INST_W(INST_W), .HALT_INST(32'h0),
    .CNT_W(CNT_W), .DRAIN_CYCLES(5), .TIMEOUT_CYCLES(500),
    .DUMP_DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .CLK     (clk),
    .RESET   (rst),
    .mon_bus (bus)
  );

  typedef struct {
    int unsigned cyc;
    int unsigned node;
    logic [0:3]  exp_halted;
  } halt_vec_t;

  halt_vec_t tbl [4];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input int unsigned node, input logic [INST_W-1:0] val);
    bus.inst_in[node*INST_W +: INST_W] = val;
  endtask

  task automatic idle_inst();
    for (int n = 0; n < NODES; n++) set_inst(n, 32'hC0DE_0000 | INST_W'(n + 1));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_halted"},     64'(bus.halted),      64'd0);
    chk({tag, "_cycle_count"}, 64'(bus.cycle_count), 64'd0);
    chk({tag, "_run_cycles"}, 64'(bus.run_cycles),  64'd0);
    chk({tag, "_timeout"},    64'(bus.timeout),     64'd0);
    chk({tag, "_dump_valid"}, 64'(bus.dump_valid),  64'd0);
    chk({tag, "_dump_node"},  64'(bus.dump_node),   64'd0);
    chk({tag, "_dump_addr"},  64'(bus.dump_addr),   64'd0);
    chk({tag, "_done"},       64'(bus.done),        64'd0);
  endtask

  // Reset, release, take the IDLE->RUN edge; returns at the start of RUN cycle 0.
  task automatic start_run(input logic [3:0] mask);
    rst = 1'b1;
    bus.node_mask  = mask;
    bus.dump_ready = 1'b0;
    idle_inst();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Counts edges from the halt edge until dump_valid rises; expected DRAIN+1 = 6.
  task automatic wait_dump(input string name);
    int lat = 1;
    while (!bus.dump_valid && lat < 20) begin
      step();
      lat++;
    end
    chk(name, 64'(lat), 64'd6);
  endtask

  // Halt sequence with all four nodes participating, ending at DUMP entry.
  task automatic sc1_run(input string tag);
    logic [0:3] exp_h = 4'b0000;
    start_run(4'b1111);
    chk({tag, "_cc_run0"}, 64'(bus.cycle_count), 64'd0);
    for (int k = 0; k <= 20; k++) begin
      idle_inst();
      if (k == 5) set_inst(1, 32'h0000_0001);
      for (int e = 0; e < 4; e++) begin
        if (tbl[e].cyc == k) begin
          set_inst(tbl[e].node, 32'h0);
          exp_h = tbl[e].exp_halted;
        end
      end
      step();
      chk($sformatf("%s_halted_c%0d", tag, k), 64'(bus.halted), 64'(exp_h));
      if (k == 9) chk({tag, "_cc10"}, 64'(bus.cycle_count), 64'd10);
    end
    idle_inst();
    chk({tag, "_run_cycles"}, 64'(bus.run_cycles), 64'd20);
    chk({tag, "_timeout0"},   64'(bus.timeout),    64'd0);
    chk({tag, "_no_valid"},   64'(bus.dump_valid), 64'd0);
    wait_dump({tag, "_drain_lat"});
    chk({tag, "_first_node"}, 64'(bus.dump_node), 64'd0);
    chk({tag, "_first_addr"}, 64'(bus.dump_addr), 64'd0);
  endtask

  initial begin
    logic [0:3] rdy_pat;
    int exp_b;
    int bad;
    int cyc;
    int first_bad;

    tbl[0] = '{cyc: 10, node: 0, exp_halted: 4'b1000};
    tbl[1] = '{cyc: 12, node: 1, exp_halted: 4'b1100};
    tbl[2] = '{cyc: 15, node: 2, exp_halted: 4'b1110};
    tbl[3] = '{cyc: 20, node: 3, exp_halted: 4'b1111};

    rst = 1'b1;
    bus.node_mask  = 4'b1111;
    bus.dump_ready = 1'b0;
    idle_inst();
    step();
    step();
    check_zero("reset");

    // Scenario 1 then backpressure pattern 1,0,0,1 up to beat 37, then reset.
    sc1_run("s1a");
    rdy_pat = 4'b1001;
    exp_b = 0; bad = 0; cyc = 0; first_bad = -1;
    while (exp_b < 37 && cyc < 400) begin
      bus.dump_ready = rdy_pat[cyc % 4];
      if (!bus.dump_valid || int'(bus.dump_node) != exp_b / DEPTH ||
          int'(bus.dump_addr) != exp_b % DEPTH) begin
        bad++;
        if (first_bad < 0) first_bad = cyc;
      end
      if (bus.dump_ready) exp_b++;
      step();
      cyc++;
    end
    chk($sformatf("bp_hold_bad_first_cyc%0d", first_bad), 64'(bad), 64'd0);
    chk("bp_beat_reached", 64'(exp_b), 64'd37);
    chk("bp_beat37_addr", 64'(bus.dump_addr), 64'd37);
    chk("bp_beat37_valid", 64'(bus.dump_valid), 64'd1);
    bus.dump_ready = 1'b0;
    rst = 1'b1;
    step();
    check_zero("mid_dump_rst");
    rst = 1'b0;

    // Rerun reproduces scenario 1, then full dump with ready held high.
    sc1_run("s1b");
    bus.dump_ready = 1'b1;
    bad = 0; first_bad = -1;
    for (int b = 0; b < NODES * DEPTH; b++) begin
      if (!bus.dump_valid || int'(bus.dump_node) != b / DEPTH ||
          int'(bus.dump_addr) != b % DEPTH) begin
        bad++;
        if (first_bad < 0) first_bad = b;
      end
      step();
    end
    chk($sformatf("full_dump_bad_first_beat%0d", first_bad), 64'(bad), 64'd0);
    chk("full_dump_valid_low", 64'(bus.dump_valid), 64'd0);
    chk("full_dump_done", 64'(bus.done), 64'd1);
    chk("full_dump_timeout", 64'(bus.timeout), 64'd0);
    for (int n = 0; n < NODES; n++) set_inst(n, 32'h0);
    step();
    step();
    chk("done_sticky", 64'(bus.done), 64'd1);
    chk("done_no_valid", 64'(bus.dump_valid), 64'd0);

    // Timeout: node 0 never halts.
    start_run(4'b0001);
    for (int k = 0; k < 499; k++) step();
    chk("tmo_pre_timeout", 64'(bus.timeout), 64'd0);
    chk("tmo_pre_valid", 64'(bus.dump_valid), 64'd0);
    chk("tmo_pre_cc", 64'(bus.cycle_count), 64'd499);
    step();
    chk("tmo_timeout", 64'(bus.timeout), 64'd1);
    chk("tmo_run_cycles", 64'(bus.run_cycles), 64'd499);
    chk("tmo_valid", 64'(bus.dump_valid), 64'd1);
    chk("tmo_node", 64'(bus.dump_node), 64'd0);
    chk("tmo_addr", 64'(bus.dump_addr), 64'd0);
    chk("tmo_halted", 64'(bus.halted), 64'd0);

    // Halt on the final timeout cycle: halt wins.
    start_run(4'b1111);
    for (int k = 0; k < 499; k++) step();
    for (int n = 0; n < NODES; n++) set_inst(n, 32'h0);
    step();
    idle_inst();
    chk("h499_timeout", 64'(bus.timeout), 64'd0);
    chk("h499_run_cycles", 64'(bus.run_cycles), 64'd499);
    chk("h499_valid", 64'(bus.dump_valid), 64'd0);
    chk("h499_halted", 64'(bus.halted), 64'hF);
    wait_dump("h499_drain_lat");

    // Empty mask: immediate completion, masked nodes never flagged.
    start_run(4'b0000);
    for (int n = 0; n < NODES; n++) set_inst(n, 32'h0);
    step();
    chk("mask0_run_cycles", 64'(bus.run_cycles), 64'd0);
    chk("mask0_halted", 64'(bus.halted), 64'd0);
    chk("mask0_valid", 64'(bus.dump_valid), 64'd0);
    wait_dump("mask0_drain_lat");
    chk("mask0_timeout", 64'(bus.timeout), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
